// File: rtl/m_write_back_pkg.sv
// Shared write-back definitions: register-file geometry, queue defaults and the queue entry type.
// The optional pending-load scoreboard is enabled by defining WB_SCOREBOARD_EN.
`ifndef REG_ADDR_BITS
`define REG_ADDR_BITS 5
`endif
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef NUM_OF_REG
`define NUM_OF_REG 32
`endif
`ifndef WB_LQ_DEPTH
`define WB_LQ_DEPTH 4
`endif
`ifndef WB_STARVE_MAX
`define WB_STARVE_MAX 4
`endif

package m_write_back_pkg;

   localparam int REG_ADDR_W = `REG_ADDR_BITS;
   localparam int WORD_W     = `WORD_BITS;
   localparam int NUM_REG    = `NUM_OF_REG;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [WORD_W-1:0]     val;
   } wbEntry_t;

   localparam int ENTRY_W = $bits(wbEntry_t);

   // One-hot register mask; r0 is hard-wired and never marked.
   function automatic logic [NUM_REG-1:0] regMask(input logic [REG_ADDR_W-1:0] addr);
      regMask       = '0;
      regMask[addr] = (addr != '0);
   endfunction

endpackage

// File: rtl/m_write_back_queue.sv
// Load-result queue for the write-back stage: synchronous FIFO with push/pop/full/empty.
// No fall-through: a push into an empty queue is visible at the head next cycle.
module mWbQueue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iPush,
   input  logic [WIDTH-1:0] iPushData,
   input  logic             iPop,
   output logic [WIDTH-1:0] oHead,
   output logic             oFull,
   output logic             oEmpty
);

   localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             doPush;
   logic             doPop;

   assign oFull  = (count == CNT_W'(DEPTH));
   assign oEmpty = (count == '0);
   assign doPush = iPush && !oFull;
   assign doPop  = iPop && !oEmpty;
   assign oHead  = mem[rdPtr];

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush && !rst) mem[wrPtr] <= iPushData;
   end

endmodule

// File: rtl/m_write_back.sv
// Write-back arbiter: merges ALU and queued load results into one register-file write port.
// WB_SCOREBOARD_EN adds the per-register outstanding-load bitmap on oPending.
module m_write_back
   import m_write_back_pkg::*;
#(
   parameter int LQ_DEPTH   = `WB_LQ_DEPTH,
   parameter int STARVE_MAX = `WB_STARVE_MAX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iAluValid,
   input  logic [REG_ADDR_W-1:0] iAluAddr,
   input  logic [WORD_W-1:0]     iAluVal,
   output logic                  oAluStall,
   input  logic                  iLdValid,
   input  logic [REG_ADDR_W-1:0] iLdAddr,
   input  logic [WORD_W-1:0]     iLdVal,
   output logic                  oLdReady,
   input  logic                  iIssueValid,
   input  logic [REG_ADDR_W-1:0] iIssueAddr,
   output logic                  oDstValid,
   output logic [REG_ADDR_W-1:0] oDstAddr,
   output logic [WORD_W-1:0]     oDstVal,
   output logic [NUM_REG-1:0]    oPending
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   wbEntry_t         pushEntry;
   wbEntry_t         headEntry;
   logic             lqFull;
   logic             lqEmpty;
   logic             lqPush;
   logic             lqPop;
   logic             aluWin;
   logic             starved;
   logic [CNT_W-1:0] starveCnt;

   assign pushEntry = '{addr: iLdAddr, val: iLdVal};

   mWbQueue #(
      .DEPTH (LQ_DEPTH),
      .WIDTH (ENTRY_W)
   ) uQueue (
      .clk       (clk),
      .rst       (rst),
      .iPush     (lqPush),
      .iPushData (pushEntry),
      .iPop      (lqPop),
      .oHead     (headEntry),
      .oFull     (lqFull),
      .oEmpty    (lqEmpty)
   );

   // The counter only reaches its limit with loads waiting, so a starved cycle always pops.
   assign starved   = (starveCnt == CNT_W'(STARVE_MAX));
   assign oAluStall = starved;
   assign oLdReady  = !lqFull;

   // r0 writes are accepted on both paths and simply dropped.
   assign aluWin = iAluValid && !starved && (iAluAddr != '0);
   assign lqPush = iLdValid && !lqFull && (iLdAddr != '0);
   assign lqPop  = !aluWin && !lqEmpty;

   always_ff @(posedge clk) begin
      if (rst) begin
         starveCnt <= '0;
      end else if (aluWin && !lqEmpty) begin
         starveCnt <= starveCnt + CNT_W'(1);
      end else begin
         starveCnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oDstValid <= 1'b0;
         oDstAddr  <= '0;
         oDstVal   <= '0;
      end else begin
         oDstValid <= aluWin || lqPop;
         if (aluWin) begin
            oDstAddr <= iAluAddr;
            oDstVal  <= iAluVal;
         end else if (lqPop) begin
            oDstAddr <= headEntry.addr;
            oDstVal  <= headEntry.val;
         end
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [NUM_REG-1:0] pendQ;
   logic [NUM_REG-1:0] setMask;
   logic [NUM_REG-1:0] clrMask;

   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (iIssueValid) setMask = regMask(iIssueAddr);
      if (lqPop)       clrMask = regMask(headEntry.addr);
   end

   // Set is applied after clear so a re-issue in the pop cycle keeps the bit.
   always_ff @(posedge clk) begin
      if (rst) pendQ <= '0;
      else     pendQ <= (pendQ & ~clrMask) | setMask;
   end

   assign oPending = pendQ;
`else
   logic unusedIssue;
   assign unusedIssue = ^{iIssueValid, iIssueAddr};
   assign oPending    = '0;
`endif

endmodule

// File: tb/tb_m_write_back.sv
// Self-checking bench for m_write_back: directed scenarios plus randomized traffic against a queue-based model.
`ifndef REG_ADDR_BITS
`define REG_ADDR_BITS 5
`endif
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef NUM_OF_REG
`define NUM_OF_REG 32
`endif

module tb_m_write_back;

   localparam int AW = `REG_ADDR_BITS;
   localparam int DW = `WORD_BITS;
   localparam int NR = `NUM_OF_REG;
   localparam int LQ_DEPTH = 4;
   localparam int STARVE_MAX = 4;
`ifdef WB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          iAluValid;
   logic [AW-1:0] iAluAddr;
   logic [DW-1:0] iAluVal;
   logic          oAluStall;
   logic          iLdValid;
   logic [AW-1:0] iLdAddr;
   logic [DW-1:0] iLdVal;
   logic          oLdReady;
   logic          iIssueValid;
   logic [AW-1:0] iIssueAddr;
   logic          oDstValid;
   logic [AW-1:0] oDstAddr;
   logic [DW-1:0] oDstVal;
   logic [NR-1:0] oPending;

   m_write_back #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .iAluValid(iAluValid), .iAluAddr(iAluAddr), .iAluVal(iAluVal), .oAluStall(oAluStall),
      .iLdValid(iLdValid), .iLdAddr(iLdAddr), .iLdVal(iLdVal), .oLdReady(oLdReady),
      .iIssueValid(iIssueValid), .iIssueAddr(iIssueAddr),
      .oDstValid(oDstValid), .oDstAddr(oDstAddr), .oDstVal(oDstVal), .oPending(oPending)
   );

   always #5 clk = ~clk;

   int nCompared = 0;
   int nMismatched = 0;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: queue of pending loads, starvation count, pending bitmap, expected write port.
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] val; } ent_t;
   ent_t          mq[$];
   int            starve;
   logic [NR-1:0] pend;
   bit            expValid;
   logic [AW-1:0] expAddr;
   logic [DW-1:0] expVal;
   bit            lastStall;

   task automatic modelReset();
      mq.delete();
      starve = 0;
      pend = '0;
      expValid = 1'b0;
      expAddr = '0;
      expVal = '0;
      lastStall = 1'b0;
   endtask

   task automatic step(input logic r, input logic aV, input logic [AW-1:0] aA, input logic [DW-1:0] aD,
                       input logic lV, input logic [AW-1:0] lA, input logic [DW-1:0] lD,
                       input logic iV, input logic [AW-1:0] iA);
      bit stallM, full, win, pop;
      ent_t h;
      rst = r; iAluValid = aV; iAluAddr = aA; iAluVal = aD;
      iLdValid = lV; iLdAddr = lA; iLdVal = lD; iIssueValid = iV; iIssueAddr = iA;
      @(negedge clk);
      if (r) begin
         modelReset();
      end else begin
         stallM = (starve == STARVE_MAX);
         full = (mq.size() == LQ_DEPTH);
         checkVal("ld_ready", oLdReady, !full);
         checkVal("alu_stall", oAluStall, stallM);
         checkVal("dst_valid", oDstValid, expValid);
         if (expValid) begin
            checkVal("dst_addr", oDstAddr, expAddr);
            checkVal("dst_val", oDstVal, expVal);
         end
         checkVal("pending", oPending, pend);
         win = aV && !stallM && (aA != 0);
         pop = !win && (mq.size() != 0);
         starve = (win && mq.size() != 0) ? starve + 1 : 0;
         expValid = win || pop;
         if (win) begin
            expAddr = aA;
            expVal = aD;
         end else if (pop) begin
            h = mq.pop_front();
            expAddr = h.addr;
            expVal = h.val;
            if (SB_EN) pend[h.addr] = 1'b0;
         end
         if (SB_EN && iV && iA != 0) pend[iA] = 1'b1;
         if (lV && !full && lA != 0) mq.push_back('{addr: lA, val: lD});
         lastStall = stallM && aV;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          r, aV, lV, iV, holdAlu;
      logic [AW-1:0] aA, lA, iA;
      logic [DW-1:0] aD, lD;
      int            nStall;

      rst = 1'b1; iAluValid = 0; iAluAddr = '0; iAluVal = '0;
      iLdValid = 0; iLdAddr = '0; iLdVal = '0; iIssueValid = 0; iIssueAddr = '0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      checkVal("rst_valid", oDstValid, 0);
      checkVal("rst_addr", oDstAddr, 0);
      checkVal("rst_val", oDstVal, 0);
      checkVal("rst_pending", oPending, 0);
      checkVal("rst_ld_ready", oLdReady, 1);
      checkVal("rst_stall", oAluStall, 0);

      // Single ALU write appears one cycle later for one cycle.
      idle(2);
      step(1'b0, 1'b1, AW'(3), DW'(32'h1234), 1'b0, '0, '0, 1'b0, '0);
      checkVal("alu_only_valid", oDstValid, 1);
      checkVal("alu_only_addr", oDstAddr, 3);
      checkVal("alu_only_val", oDstVal, 32'h1234);
      idle(1);
      checkVal("alu_only_once", oDstValid, 0);

      // Fill the queue behind a busy ALU, then drain in order.
      for (int i = 1; i <= 4; i++)
         step(1'b0, 1'b1, AW'(10), DW'(100 + i), 1'b1, AW'(i), DW'(32'hA0 + i), 1'b0, '0);
      checkVal("lq_full_ready", oLdReady, 0);
      step(1'b0, 1'b1, AW'(10), DW'(105), 1'b1, AW'(5), DW'(32'hA5), 1'b0, '0);
      for (int i = 1; i <= 4; i++) begin
         idle(1);
         checkVal("drain_valid", oDstValid, 1);
         checkVal("drain_addr", oDstAddr, i);
      end
      idle(1);
      checkVal("drain_done", oDstValid, 0);

      // Continuous ALU traffic with one queued load: exactly one starvation stall.
      nStall = 0;
      aD = 32'd500;
      step(1'b0, 1'b1, AW'(5), aD, 1'b1, AW'(9), DW'(32'hAAAA), 1'b0, '0);
      for (int i = 0; i < 9; i++) begin
         if (oAluStall) nStall++;
         if (!lastStall) aD = aD + 1;
         step(1'b0, 1'b1, AW'(5), aD, 1'b0, '0, '0, 1'b0, '0);
         if (i == 4) begin
            checkVal("starve_load_addr", oDstAddr, 9);
            checkVal("starve_load_val", oDstVal, 32'hAAAA);
         end
         if (i == 5) checkVal("starve_held_val", oDstVal, 32'd505);
      end
      checkVal("starve_count", nStall, 1);
      idle(2);

      // Pending bitmap around a load to r7, including re-issue in the pop cycle.
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(7));
      checkVal("pend7_issued", oPending[7], SB_EN);
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), DW'(77), 1'b0, '0);
      checkVal("pend7_queued", oPending[7], SB_EN);
      idle(1);
      checkVal("pend7_popped", oPending[7], 0);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(7));
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), DW'(78), 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(7));
      checkVal("pend7_reissue", oPending[7], SB_EN);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(0));
      checkVal("pend0_zero", oPending[0], 0);
      idle(1);

      // r0 writes are dropped; reset discards queued loads.
      step(1'b0, 1'b1, AW'(0), DW'(11), 1'b0, '0, '0, 1'b0, '0);
      checkVal("r0_alu", oDstValid, 0);
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), DW'(12), 1'b0, '0);
      idle(1);
      checkVal("r0_load", oDstValid, 0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, AW'(9), DW'(i), 1'b1, AW'(11 + i), DW'(200 + i), 1'b1, AW'(11 + i));
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      checkVal("rst_mid_pending", oPending, 0);
      checkVal("rst_mid_ready", oLdReady, 1);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         checkVal("rst_mid_no_emit", oDstValid, 0);
      end

      // Randomized traffic; a stalled ALU result is held upstream.
      holdAlu = 1'b0; aV = 0; aA = '0; aD = '0;
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 199) == 0);
         if (!holdAlu) begin
            aV = ($urandom_range(0, 99) < 75);
            aA = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, NR - 1));
            aD = $urandom;
         end
         lV = ($urandom_range(0, 99) < 40);
         lA = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, NR - 1));
         lD = $urandom;
         iV = ($urandom_range(0, 99) < 30);
         iA = AW'($urandom_range(0, NR - 1));
         step(r, aV, aA, aD, lV, lA, lD, iV, iA);
         holdAlu = lastStall && !r;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
